// File: rtl/button_pkg.sv
// button_pkg: shared FSM state encoding and 12 MHz board defaults for button_event_decoder
package button_pkg;
  typedef enum logic [1:0] {ARM, IDLE, PRESSED, REPEAT} state_t;
  localparam int DEF_LONG_COUNT = 12000000;
  localparam int DEF_REPEAT_COUNT = 2400000;
endpackage

// File: rtl/button_event_decoder_if.sv
// button_event_decoder_if: button level/enable inputs and decoded event outputs
// master drives db_in/enable and observes events; slave (the decoder) does the reverse
interface button_event_decoder_if;
  import button_pkg::*;
  logic db_in;
  logic enable;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;
  logic [7:0] repeat_cnt;
  modport master (output db_in, enable, input press_pulse, release_pulse, long_pulse, repeat_pulse, held, repeat_cnt);
  modport slave (input db_in, enable, output press_pulse, release_pulse, long_pulse, repeat_pulse, held, repeat_cnt);
endinterface

// File: rtl/evt_timer.sv
// evt_timer: hold timer that counts while run_i and flags when it equals term_i
// ports: clk, reset (sync, active-high), clear_i (zero the count), run_i (count up), term_i (terminal value), hit_o (count == term_i)
module evt_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             hit_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= (reset || clear_i) ? '0 : run_i ? cnt_q + CNT_W'(1) : cnt_q;
  assign hit_o = cnt_q == term_i;
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/release/long/repeat pulses
// ports: clk, reset (sync, active-high), bus (slave: db_in, enable in; press/release/long/repeat pulses, held, repeat_cnt out)
module button_event_decoder
  import button_pkg::*;
#(
  parameter int CNT_W        = 24,
  parameter int LONG_COUNT   = DEF_LONG_COUNT,
  parameter int REPEAT_COUNT = DEF_REPEAT_COUNT,
  parameter bit REPEAT_EN    = 1'b1
) (
  input logic clk,
  input logic reset,
  button_event_decoder_if.slave bus
);
  localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;
  if (LONG_COUNT < 2 || REPEAT_COUNT < 2 || longint'(LONG_COUNT) > MAX_CNT || longint'(REPEAT_COUNT) > MAX_CNT) begin : g_bad_params
    $error("button_event_decoder: LONG_COUNT/REPEAT_COUNT must lie in [2, 2**CNT_W-1]");
  end
  state_t state_q, state_d;
  logic press_q, release_q, long_q, repeat_q, held_q;
  logic press_d, release_d, long_d, repeat_d, held_d;
  logic [7:0] cnt_q, cnt_d;
  logic hit, clear, run;
  logic [CNT_W-1:0] term;
  assign term = state_q == PRESSED ? CNT_W'(LONG_COUNT - 1) : CNT_W'(REPEAT_COUNT - 1);
  assign run = state_q == PRESSED || (state_q == REPEAT && REPEAT_EN);
  // restart on every state change and every terminal hit; idle states keep it parked at 0
  assign clear = !bus.enable || !bus.db_in || !(state_q inside {PRESSED, REPEAT}) || hit;
  evt_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear_i(clear),
    .run_i  (run),
    .term_i (term),
    .hit_o  (hit)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    press_d = 1'b0;
    release_d = 1'b0;
    long_d = 1'b0;
    repeat_d = 1'b0;
    if (!bus.enable) state_d = ARM;
    else
      case (state_q)
        ARM: if (!bus.db_in) state_d = IDLE;
        IDLE:
          if (bus.db_in) begin
            state_d = PRESSED;
            press_d = 1'b1;
            cnt_d = '0;
          end
        PRESSED:
          if (!bus.db_in) begin
            state_d = IDLE;
            release_d = 1'b1;
          end else if (hit) begin
            state_d = REPEAT;
            long_d = 1'b1;
          end
        REPEAT:
          if (!bus.db_in) begin
            state_d = IDLE;
            release_d = 1'b1;
          end else if (REPEAT_EN && hit) begin
            repeat_d = 1'b1;
            cnt_d = cnt_q + 8'(cnt_q != 8'hff);
          end
      endcase
    held_d = state_d inside {PRESSED, REPEAT};
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= ARM;
      cnt_q <= '0;
      {press_q, release_q, long_q, repeat_q, held_q} <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      {press_q, release_q, long_q, repeat_q, held_q} <= {press_d, release_d, long_d, repeat_d, held_d};
    end
  assign bus.press_pulse = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse = long_q;
  assign bus.repeat_pulse = repeat_q;
  assign bus.held = held_q;
  assign bus.repeat_cnt = cnt_q;
endmodule
